// File: rtl/simple_dualportram_stream_reader.sv
// Burst reader: pulls a range of words out of a registered-output RAM and
// presents them as a valid/ready stream through a small credit-checked FIFO.
module simple_dualportram_stream_reader #(
   parameter int WIDTH      = 32,
   parameter int DEPTH      = 10,
   parameter int FIFO_WORDS = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [31:0]      base,
   input  logic [31:0]      count,
   output logic             busy,
   output logic             done,
   output logic             err,
   input  logic [31:0]      ram_length,
   output logic [31:0]      ram_address,
   output logic [WIDTH-1:0] ram_din,
   output logic             ram_we,
   output logic             ram_oe,
   input  logic [WIDTH-1:0] ram_dout,
   output logic [WIDTH-1:0] m_data,
   output logic             m_valid,
   input  logic             m_ready
);

   //  state | meaning
   //  IDLE  | waiting for start; zero-length and out-of-range requests finish here
   //  RUN   | issuing reads and draining the FIFO until the last word is accepted

   localparam int PW = $clog2(FIFO_WORDS);
   localparam int CW = PW + 1;
   localparam logic [CW:0] FIFO_CAP = (CW+1)'(FIFO_WORDS);

   if (FIFO_WORDS < 4 || (FIFO_WORDS & (FIFO_WORDS - 1)) != 0 || DEPTH < 1 || DEPTH > 32)
   begin : g_bad_params
      $error("simple_dualportram_stream_reader: illegal FIFO_WORDS or DEPTH");
   end

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t            state, state_next;
   logic [31:0]       base_q, count_q, issued, popped;
   logic [31:0]       ram_address_q;
   logic              ram_oe_q;
   logic              cap_valid;
   logic [WIDTH-1:0]  fifo_mem [FIFO_WORDS];
   logic [PW-1:0]     wr_ptr, rd_ptr;
   logic [CW-1:0]     fifo_count;
   logic              done_q, err_q;

   logic              issue, accept, pop;
   logic              done_next, err_next;
   logic [32:0]       range_sum;
   logic              range_ok;
   logic [1:0]        inflight;
   logic [CW:0]       committed;

   assign m_valid  = (fifo_count != '0);
   assign m_data   = m_valid ? fifo_mem[rd_ptr] : '0;
   assign pop      = m_valid && m_ready;
   assign inflight = {1'b0, ram_oe_q} + {1'b0, cap_valid};
   assign committed = {1'b0, fifo_count} + (CW+1)'(inflight);
   // 33-bit sum so a base near 2^32 cannot wrap into a falsely valid range
   assign range_sum = {1'b0, base} + {1'b0, count};
   assign range_ok  = (range_sum <= {1'b0, ram_length});

   assign busy        = (state == RUN);
   assign done        = done_q;
   assign err         = err_q;
   assign ram_address = ram_address_q;
   assign ram_oe      = ram_oe_q;
   assign ram_din     = '0;
   assign ram_we      = 1'b0;

   always_comb begin
      state_next = state;
      issue      = 1'b0;
      accept     = 1'b0;
      done_next  = 1'b0;
      err_next   = err_q;
      case (state)
         IDLE: begin
            if (start) begin
               if (count == 32'd0) begin
                  done_next = 1'b1;
                  err_next  = 1'b0;
               end else if (!range_ok) begin
                  done_next = 1'b1;
                  err_next  = 1'b1;
               end else begin
                  accept     = 1'b1;
                  err_next   = 1'b0;
                  state_next = RUN;
               end
            end
         end
         RUN: begin
            issue = (issued < count_q) && (committed < FIFO_CAP);
            if (pop && (popped == count_q - 32'd1)) begin
               done_next  = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         base_q        <= '0;
         count_q       <= '0;
         issued        <= '0;
         popped        <= '0;
         ram_address_q <= '0;
         ram_oe_q      <= 1'b0;
         cap_valid     <= 1'b0;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         fifo_count    <= '0;
         done_q        <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         done_q    <= done_next;
         err_q     <= err_next;
         ram_oe_q  <= issue;
         cap_valid <= ram_oe_q;
         if (accept) begin
            base_q  <= base;
            count_q <= count;
            issued  <= '0;
            popped  <= '0;
         end
         if (issue) begin
            ram_address_q <= base_q + issued;
            issued        <= issued + 32'd1;
         end
         if (pop) begin
            popped <= popped + 32'd1;
            rd_ptr <= rd_ptr + PW'(1);
         end
         if (cap_valid) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         case ({cap_valid, pop})
            2'b10:   fifo_count <= fifo_count + CW'(1);
            2'b01:   fifo_count <= fifo_count - CW'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   // Storage needs no reset: m_data is masked while the FIFO is empty
   always_ff @(posedge clk) begin
      if (cap_valid) begin
         fifo_mem[wr_ptr] <= ram_dout;
      end
   end

endmodule
